// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch-stage types and constants used by the front end and its decoder interface.
// No logic; latency and backpressure are defined by the modules that import it.
package inst_fetch_unit_pkg;

   localparam int cXLEN = 32;
   localparam logic [cXLEN-1:0] cNopInst = 32'h0000_0013;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } tFetchState;

   typedef struct packed {
      logic [cXLEN-1:0] instr;
      logic [cXLEN-1:0] pc;
      logic             valid;
   } tFetchOut;

endpackage

// File: rtl/inst_fetch_unit_inst_mem.sv
// Instruction RAM: one write port, one registered read port (read data one cycle after address).
// No flow control; the read address is sampled every cycle and contents are never cleared.
module inst_mem
   import inst_fetch_unit_pkg::*;
#(
   parameter int XLEN      = cXLEN,
   parameter int MEM_DEPTH = 256
) (
   input  logic                         clk,
   input  logic                         we_i,
   input  logic [$clog2(MEM_DEPTH)-1:0] waddr_i,
   input  logic [XLEN-1:0]              wdata_i,
   input  logic [$clog2(MEM_DEPTH)-1:0] raddr_i,
   output logic [XLEN-1:0]              rdata_o
);

   logic [XLEN-1:0] mem_q [MEM_DEPTH];
   logic [XLEN-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Loads a program into private RAM, then streams one instruction per cycle to the decoder.
// First word valid two cycles after start; valid/ready stalls hold the output, redirect inserts one bubble.
module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
#(
   parameter int              XLEN      = cXLEN,
   parameter int              MEM_DEPTH = 256,
   parameter logic [XLEN-1:0] RESET_PC  = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start_i,
   input  logic [XLEN-1:0]              inst_wdata_i,
   input  logic                         inst_wen_i,
   output logic [XLEN-1:0]              instr_o,
   output logic [XLEN-1:0]              pc_o,
   output logic                         valid_o,
   input  logic                         ready_i,
   input  logic                         redirect_i,
   input  logic [XLEN-1:0]              redirect_pc_i,
   output logic [$clog2(MEM_DEPTH):0]   load_count_o,
   output logic                         load_ovf_o,
   output logic                         misalign_o,
   output logic                         halt_o
);

   localparam int AW = $clog2(MEM_DEPTH);
   localparam int CW = AW + 1;

   tFetchState      state_q, state_d;
   logic [XLEN-1:0] fpc_q, fpc_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            valid_q, valid_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q, ovf_d;
   logic            mis_q, mis_d;
   logic            mem_we;
   logic [AW-1:0]   raddr;
   logic [XLEN-1:0] rdata;
   logic            stall;
   logic            fetch_ok;
   logic            count_full;
   tFetchOut        fetch_out;

   assign stall      = valid_q && !ready_i;
   // Upper PC bits take part in the compare, so addresses past the RAM never alias back in.
   assign fetch_ok   = (fpc_q >> 2) < XLEN'(count_q);
   assign count_full = (count_q == CW'(MEM_DEPTH));

   inst_mem #(
      .XLEN      (XLEN),
      .MEM_DEPTH (MEM_DEPTH)
   ) u_inst_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (count_q[AW-1:0]),
      .wdata_i (inst_wdata_i),
      .raddr_i (raddr),
      .rdata_o (rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD: begin
            if (start_i) begin
               state_d = (count_q == '0 && !inst_wen_i) ? HALT : RUN;
            end
         end
         RUN: begin
            if (!redirect_i && !stall && !fetch_ok) begin
               state_d = HALT;
            end
         end
         HALT:    state_d = HALT;
         default: state_d = LOAD;
      endcase
   end

   always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q;
      mis_d   = mis_q;
      fpc_d   = fpc_q;
      pc_d    = pc_q;
      valid_d = 1'b0;
      mem_we  = 1'b0;
      raddr   = fpc_q[AW+1:2];
      halt_o  = (state_q == HALT);
      case (state_q)
         LOAD: begin
            if (inst_wen_i) begin
               if (count_full) begin
                  ovf_d = 1'b1;
               end else begin
                  mem_we  = 1'b1;
                  count_d = count_q + 1'b1;
               end
            end
            if (start_i) begin
               fpc_d = RESET_PC;
            end
         end
         RUN: begin
            if (redirect_i) begin
               fpc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
               if (redirect_pc_i[1:0] != 2'b00) begin
                  mis_d = 1'b1;
               end
            end else if (stall) begin
               // Re-read the held word so the registered RAM output stays aligned with pc_q.
               raddr   = pc_q[AW+1:2];
               valid_d = 1'b1;
            end else if (fetch_ok) begin
               valid_d = 1'b1;
               pc_d    = fpc_q;
               fpc_d   = fpc_q + XLEN'(4);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fpc_q   <= RESET_PC;
         pc_q    <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         fpc_q   <= fpc_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         mis_q   <= mis_d;
      end
   end

   always_comb begin
      fetch_out.instr = valid_q ? rdata : '0;
      fetch_out.pc    = pc_q;
      fetch_out.valid = valid_q;
   end

   assign instr_o      = fetch_out.instr;
   assign pc_o         = fetch_out.pc;
   assign valid_o      = fetch_out.valid;
   assign load_count_o = count_q;
   assign load_ovf_o   = ovf_q;
   assign misalign_o   = mis_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus randomized ready/redirect traffic,
// checked against a program-order model (expected next PC, loaded words, halt cycle).
module tb_inst_fetch_unit;

   localparam int DEPTH = 256;
   localparam int BIG   = 1000000;

   logic        clk = 1'b0;
   logic        rst, start_i, inst_wen_i, ready_i, redirect_i;
   logic [31:0] inst_wdata_i, redirect_pc_i;
   logic [31:0] instr_o, pc_o;
   logic        valid_o, load_ovf_o, misalign_o, halt_o;
   logic [8:0]  load_count_o;

   int          errors = 0;
   int          checks = 0;

   logic [31:0] mem_m [DEPTH];
   int          n_ld, cyc, halt_at, stall_cnt, redir_cnt;
   logic [31:0] exp_pc;
   bit          mis_exp, ovf_exp, prev_redir, running;

   always #5 clk = ~clk;

   inst_fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start_i),
      .inst_wdata_i  (inst_wdata_i),
      .inst_wen_i    (inst_wen_i),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .load_count_o  (load_count_o),
      .load_ovf_o    (load_ovf_o),
      .misalign_o    (misalign_o),
      .halt_o        (halt_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (run cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit in_range(input logic [31:0] pc);
      return (pc >> 2) < 32'(n_ld);
   endfunction

   // One clock: check outputs at negedge, advance the model by this cycle's inputs.
   task automatic step();
      bit exp_valid;
      @(negedge clk);
      if (running) begin
         exp_valid = (cyc >= 2) && !prev_redir && in_range(exp_pc);
         chk("valid_o", valid_o, exp_valid);
         if (exp_valid) begin
            chk("pc_o", pc_o, exp_pc);
            chk("instr_o", instr_o, mem_m[exp_pc[9:2]]);
         end
         chk("halt_o", halt_o, cyc >= halt_at);
         chk("misalign_o", misalign_o, mis_exp);
         prev_redir = 1'b0;
         if (redirect_i) begin
            exp_pc = redirect_pc_i & ~32'h3;
            if (redirect_pc_i[1:0] != 2'b00) mis_exp = 1'b1;
            prev_redir = 1'b1;
            if (!in_range(exp_pc)) halt_at = cyc + 2;
         end else if (exp_valid && ready_i) begin
            exp_pc = exp_pc + 32'd4;
            if (!in_range(exp_pc)) halt_at = cyc + 1;
         end
         cyc++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start_i = 1'b0; inst_wen_i = 1'b0;
      ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      running = 1'b0; n_ld = 0; cyc = 0; mis_exp = 1'b0; ovf_exp = 1'b0;
      chk("rst_valid", valid_o, 0);
      chk("rst_instr", instr_o, 0);
      chk("rst_pc", pc_o, 0);
      chk("rst_count", load_count_o, 0);
      chk("rst_ovf", load_ovf_o, 0);
      chk("rst_misalign", misalign_o, 0);
      chk("rst_halt", halt_o, 0);
   endtask

   task automatic load_word(input logic [31:0] w);
      inst_wen_i   = 1'b1;
      inst_wdata_i = w;
      if (n_ld < DEPTH) begin
         mem_m[n_ld] = w;
         n_ld++;
      end else begin
         ovf_exp = 1'b1;
      end
      @(posedge clk);
      #1;
      inst_wen_i = 1'b0;
   endtask

   task automatic load_random(input int n);
      for (int i = 0; i < n; i++) load_word($urandom);
      chk("load_count", load_count_o, n_ld);
      chk("load_ovf", load_ovf_o, ovf_exp);
   endtask

   task automatic start_run();
      cyc = 0; running = 1'b1; prev_redir = 1'b0; exp_pc = '0;
      halt_at = (n_ld == 0) ? 1 : BIG;
      start_i = 1'b1; ready_i = 1'b1; redirect_i = 1'b0;
      step();
      start_i = 1'b0;
   endtask

   task automatic run(input int mode, input int budget, input bit expect_done);
      int r;
      stall_cnt = 0;
      redir_cnt = 0;
      for (int k = 0; k < budget && !(cyc > halt_at + 1); k++) begin
         ready_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
         case (mode)
            1: if (valid_o && pc_o == 32'h8 && stall_cnt < 3) begin
                  ready_i = 1'b0;
                  stall_cnt++;
               end
            2: if (valid_o && pc_o == 32'h10 && redir_cnt == 0) begin
                  redirect_i = 1'b1; redirect_pc_i = 32'h4; redir_cnt++;
               end
            3: if (valid_o && pc_o == 32'h8 && redir_cnt == 0) begin
                  redirect_i = 1'b1; redirect_pc_i = 32'h6; redir_cnt++;
               end else if (valid_o && pc_o == 32'h10 && redir_cnt == 1) begin
                  redirect_i = 1'b1; redirect_pc_i = 32'h40; redir_cnt++;
               end
            4: begin
               ready_i = ($urandom_range(0, 9) < 7);
               if (redir_cnt < 4 && $urandom_range(0, 15) == 0) begin
                  redir_cnt++;
                  redirect_i = 1'b1;
                  r = $urandom_range(0, 9);
                  if (r < 6)       redirect_pc_i = $urandom_range(0, n_ld - 1) * 4;
                  else if (r < 8)  redirect_pc_i = $urandom_range(0, n_ld - 1) * 4 + $urandom_range(1, 3);
                  else if (r == 8) redirect_pc_i = (n_ld + $urandom_range(0, 20)) * 4;
                  else             redirect_pc_i = 32'h400 + $urandom_range(0, n_ld - 1) * 4;
               end
            end
            default: ;
         endcase
         if (cyc < 1 || halt_at != BIG) redirect_i = 1'b0;
         step();
      end
      ready_i = 1'b0;
      redirect_i = 1'b0;
      if (expect_done) chk("run_done", halt_o, 1);
   endtask

   initial begin
      rst = 1'b1; start_i = 1'b0; inst_wen_i = 1'b0; inst_wdata_i = '0;
      ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
      running = 1'b0; cyc = 0; halt_at = BIG; exp_pc = '0;
      do_reset();

      // Three-word program streamed with ready held high.
      load_word(inst_fetch_unit_pkg::cNopInst);
      load_word(32'h0010_0093);
      load_word(32'h0020_0113);
      chk("load_count3", load_count_o, 3);
      start_run();
      run(0, 20, 1);

      // Stall for three cycles while pc_o is 8.
      do_reset();
      load_random(8);
      start_run();
      run(1, 60, 1);

      // Backward branch to 0x4 taken at pc_o 0x10.
      do_reset();
      load_random(8);
      start_run();
      run(2, 60, 1);

      // Misaligned redirect, then redirect past the program end.
      do_reset();
      load_random(8);
      start_run();
      run(3, 60, 1);
      chk("misalign_sticky", misalign_o, 1);

      // Overflowing load, then an empty program.
      do_reset();
      load_random(DEPTH + 2);
      chk("ovf_count", load_count_o, DEPTH);
      do_reset();
      start_run();
      run(0, 6, 1);

      // Reset in the middle of a run, then a fresh two-word program.
      do_reset();
      load_random(8);
      start_run();
      run(0, 4, 0);
      do_reset();
      load_random(2);
      start_run();
      run(0, 20, 1);

      for (int t = 0; t < 20; t++) begin
         do_reset();
         load_random($urandom_range(1, 40));
         start_run();
         run(4, 600, 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
